// File: rtl/rx_link_fault_monitor.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rx_link_fault_monitor                                                  |
// | Qualifies local/remote fault sequences and keeps per-type statistics.  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module rx_link_fault_monitor #(
  parameter int SEQ_THRESH = 4,
  parameter int COL_WINDOW = 128,
  parameter int CNT_W      = 16
) (
  input  logic             rxclk_2x,
  input  logic             reset,
  input  logic             enable,
  input  logic             local_fault,
  input  logic             remote_fault,
  input  logic             clr_stats,
  output logic [1:0]       link_fault,
  output logic             fault_change,
  output logic [1:0]       fault_sticky,
  output logic [CNT_W-1:0] local_fault_cnt,
  output logic [CNT_W-1:0] remote_fault_cnt
);

  localparam int c_SEQ_W = $clog2(SEQ_THRESH + 1);
  localparam int c_COL_W = $clog2(COL_WINDOW + 1);
  localparam logic [c_SEQ_W-1:0] c_SEQ_LAST = c_SEQ_W'(SEQ_THRESH - 1);
  localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(COL_WINDOW - 1);
  localparam logic [CNT_W-1:0]   c_CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DETECT = 2'd1,
    S_FAULT  = 2'd2
  } state_t;

  state_t             r_state;
  logic [1:0]         r_cur_type;
  logic [c_SEQ_W-1:0] r_seq_cnt;
  logic [c_COL_W-1:0] r_col_cnt;
  logic [1:0]         r_link_fault;
  logic               r_fault_change;
  logic [1:0]         r_fault_sticky;
  logic [CNT_W-1:0]   r_local_cnt;
  logic [CNT_W-1:0]   r_remote_cnt;

  state_t             w_state_nxt;
  logic [1:0]         w_cur_type_nxt;
  logic [c_SEQ_W-1:0] w_seq_nxt;
  logic [c_COL_W-1:0] w_col_nxt;
  logic [1:0]         w_link_nxt;
  logic               w_enter_fault;
  logic [1:0]         w_in_type;
  logic               w_fault_present;
  logic               w_match;
  logic               w_inc_local;
  logic               w_inc_remote;

  // Local wins when both indications are present in the same column.
  assign w_in_type       = local_fault ? 2'b10 : (remote_fault ? 2'b01 : 2'b00);
  assign w_fault_present = |w_in_type;
  assign w_match         = (w_in_type == r_cur_type);

  always_comb begin
    w_state_nxt    = r_state;
    w_cur_type_nxt = r_cur_type;
    w_seq_nxt      = r_seq_cnt;
    w_col_nxt      = r_col_cnt;
    w_link_nxt     = r_link_fault;
    w_enter_fault  = 1'b0;
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_link_nxt  = 2'b00;
      w_seq_nxt   = '0;
      w_col_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fault_present) begin
            w_cur_type_nxt = w_in_type;
            w_seq_nxt      = c_SEQ_W'(1);
            w_col_nxt      = '0;
            w_state_nxt    = S_DETECT;
          end
        end
        S_DETECT, S_FAULT: begin
          if (w_fault_present) begin
            w_col_nxt = '0;
            if (!w_match) begin
              // A new type restarts qualification; link_fault keeps its old value meanwhile.
              w_cur_type_nxt = w_in_type;
              w_seq_nxt      = c_SEQ_W'(1);
              w_state_nxt    = S_DETECT;
            end else if (r_state == S_DETECT) begin
              if (r_seq_cnt == c_SEQ_LAST) begin
                w_link_nxt    = r_cur_type;
                w_seq_nxt     = '0;
                w_state_nxt   = S_FAULT;
                w_enter_fault = 1'b1;
              end else begin
                w_seq_nxt = r_seq_cnt + c_SEQ_W'(1);
              end
            end
          end else if (r_col_cnt == c_COL_LAST) begin
            w_state_nxt = S_IDLE;
            w_link_nxt  = 2'b00;
            w_seq_nxt   = '0;
            w_col_nxt   = '0;
          end else begin
            w_col_nxt = r_col_cnt + c_COL_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_link_nxt  = 2'b00;
        end
      endcase
    end
  end

  assign w_inc_local  = w_enter_fault && (r_cur_type == 2'b10);
  assign w_inc_remote = w_enter_fault && (r_cur_type == 2'b01);

  always_ff @(posedge rxclk_2x or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cur_type     <= 2'b00;
      r_seq_cnt      <= '0;
      r_col_cnt      <= '0;
      r_link_fault   <= 2'b00;
      r_fault_change <= 1'b0;
      r_fault_sticky <= 2'b00;
      r_local_cnt    <= '0;
      r_remote_cnt   <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_cur_type     <= w_cur_type_nxt;
      r_seq_cnt      <= w_seq_nxt;
      r_col_cnt      <= w_col_nxt;
      r_link_fault   <= w_link_nxt;
      r_fault_change <= (w_link_nxt != r_link_fault);
      // A clear coinciding with an event clears first, then records the event.
      if (clr_stats) begin
        r_fault_sticky <= w_link_nxt;
        r_local_cnt    <= CNT_W'(w_inc_local);
        r_remote_cnt   <= CNT_W'(w_inc_remote);
      end else begin
        r_fault_sticky <= r_fault_sticky | w_link_nxt;
        if (w_inc_local && (r_local_cnt != c_CNT_MAX))
          r_local_cnt <= r_local_cnt + CNT_W'(1);
        if (w_inc_remote && (r_remote_cnt != c_CNT_MAX))
          r_remote_cnt <= r_remote_cnt + CNT_W'(1);
      end
    end
  end

  assign link_fault       = r_link_fault;
  assign fault_change     = r_fault_change;
  assign fault_sticky     = r_fault_sticky;
  assign local_fault_cnt  = r_local_cnt;
  assign remote_fault_cnt = r_remote_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rx_link_fault_monitor.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_rx_link_fault_monitor                                               |
// | Scoreboard bench: reference model feeds a queue, monitor compares.     |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_rx_link_fault_monitor;

  localparam int SEQ_THRESH = 4;
  localparam int COL_WINDOW = 128;

  logic        rxclk_2x = 1'b0;
  logic        reset;
  logic        enable = 1'b0;
  logic        local_fault = 1'b0;
  logic        remote_fault = 1'b0;
  logic        clr_stats = 1'b0;
  logic [1:0]  link_fault, link_fault2;
  logic        fault_change, fault_change2;
  logic [1:0]  fault_sticky, fault_sticky2;
  logic [15:0] local_fault_cnt, remote_fault_cnt;
  logic [1:0]  local_fault_cnt2, remote_fault_cnt2;

  rx_link_fault_monitor dut (
    .rxclk_2x(rxclk_2x), .reset(reset), .enable(enable),
    .local_fault(local_fault), .remote_fault(remote_fault), .clr_stats(clr_stats),
    .link_fault(link_fault), .fault_change(fault_change), .fault_sticky(fault_sticky),
    .local_fault_cnt(local_fault_cnt), .remote_fault_cnt(remote_fault_cnt)
  );

  rx_link_fault_monitor #(.CNT_W(2)) dut_sat (
    .rxclk_2x(rxclk_2x), .reset(reset), .enable(enable),
    .local_fault(local_fault), .remote_fault(remote_fault), .clr_stats(clr_stats),
    .link_fault(link_fault2), .fault_change(fault_change2), .fault_sticky(fault_sticky2),
    .local_fault_cnt(local_fault_cnt2), .remote_fault_cnt(remote_fault_cnt2)
  );

  always #5 rxclk_2x = ~rxclk_2x;

  typedef struct packed {
    logic [1:0]  lf;
    logic        chg;
    logic [1:0]  st;
    logic [15:0] lc;
    logic [15:0] rc;
    logic [1:0]  lc2;
    logic [1:0]  rc2;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference model: shown value, candidate type, run length and quiet length.
  int m_shown, m_cand, m_run, m_quiet, m_sticky;
  int m_lc, m_rc, m_lc2, m_rc2;
  bit m_tracking;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic push_expect(input int prev_shown);
    exp_t e;
    e.lf  = 2'(m_shown);
    e.chg = (m_shown != prev_shown);
    e.st  = 2'(m_sticky);
    e.lc  = 16'(m_lc);
    e.rc  = 16'(m_rc);
    e.lc2 = 2'(m_lc2);
    e.rc2 = 2'(m_rc2);
    sb_q.push_back(e);
  endtask

  task automatic model_reset();
    m_shown = 0; m_cand = 0; m_run = 0; m_quiet = 0; m_sticky = 0;
    m_lc = 0; m_rc = 0; m_lc2 = 0; m_rc2 = 0; m_tracking = 0;
  endtask

  task automatic model_step(input bit lf, input bit rf, input bit en, input bit clr);
    int t, prev;
    bit entry;
    t = lf ? 2 : (rf ? 1 : 0);
    prev = m_shown;
    entry = 0;
    if (!en) begin
      m_tracking = 0; m_shown = 0; m_run = 0; m_quiet = 0;
    end else if (t != 0) begin
      m_quiet = 0;
      if (!m_tracking || t != m_cand) begin
        m_tracking = 1; m_cand = t; m_run = 1;
      end else if (m_run < SEQ_THRESH) begin
        m_run++;
        if (m_run == SEQ_THRESH) begin
          m_shown = m_cand;
          entry = 1;
        end
      end
    end else if (m_tracking) begin
      m_quiet++;
      if (m_quiet == COL_WINDOW) begin
        m_tracking = 0; m_shown = 0; m_run = 0; m_quiet = 0;
      end
    end
    if (clr) begin
      m_sticky = m_shown;
      m_lc = 0; m_rc = 0; m_lc2 = 0; m_rc2 = 0;
    end else begin
      m_sticky = m_sticky | m_shown;
    end
    if (entry && m_cand == 2) begin
      m_lc = (m_lc < 65535) ? m_lc + 1 : m_lc;
      m_lc2 = (m_lc2 < 3) ? m_lc2 + 1 : m_lc2;
    end
    if (entry && m_cand == 1) begin
      m_rc = (m_rc < 65535) ? m_rc + 1 : m_rc;
      m_rc2 = (m_rc2 < 3) ? m_rc2 + 1 : m_rc2;
    end
    push_expect(prev);
  endtask

  task automatic col(input bit lf, input bit rf, input bit en, input bit clr);
    @(negedge rxclk_2x);
    reset = 1'b0;
    local_fault = lf; remote_fault = rf; enable = en; clr_stats = clr;
    model_step(lf, rf, en, clr);
  endtask

  task automatic run_cols(input int n, input bit lf, input bit rf);
    for (int i = 0; i < n; i++) col(lf, rf, 1'b1, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(negedge rxclk_2x);
    reset = 1'b1;
    local_fault = 1'b0; remote_fault = 1'b0; enable = 1'b0; clr_stats = 1'b0;
    #1;
    chk("rst_async_link", 16'(link_fault), 16'h0);
    chk("rst_async_sticky", 16'(fault_sticky), 16'h0);
    chk("rst_async_lcnt", local_fault_cnt, 16'h0);
    chk("rst_async_rcnt", remote_fault_cnt, 16'h0);
    model_reset();
    push_expect(0);
    for (int i = 1; i < n; i++) begin
      @(negedge rxclk_2x);
      push_expect(0);
    end
  endtask

  always @(posedge rxclk_2x) begin
    #1;
    cyc++;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("link_fault", 16'(link_fault), 16'(mon_e.lf));
      chk("fault_change", 16'(fault_change), 16'(mon_e.chg));
      chk("fault_sticky", 16'(fault_sticky), 16'(mon_e.st));
      chk("local_fault_cnt", local_fault_cnt, mon_e.lc);
      chk("remote_fault_cnt", remote_fault_cnt, mon_e.rc);
      chk("sat_link_fault", 16'(link_fault2), 16'(mon_e.lf));
      chk("sat_local_cnt", 16'(local_fault_cnt2), 16'(mon_e.lc2));
      chk("sat_remote_cnt", 16'(remote_fault_cnt2), 16'(mon_e.rc2));
    end
  end

  initial begin
    int r, n, ty, t;
    reset = 1'b1;
    model_reset();
    do_reset(2);

    // Basic local qualification, then window clear.
    run_cols(4, 1'b1, 1'b0);
    run_cols(COL_WINDOW, 1'b0, 1'b0);
    // Remote run broken by a local column.
    run_cols(3, 1'b0, 1'b1);
    run_cols(4, 1'b1, 1'b0);
    run_cols(COL_WINDOW, 1'b0, 1'b0);
    // Gap of one less than the window does not clear.
    run_cols(4, 1'b1, 1'b0);
    run_cols(COL_WINDOW - 1, 1'b0, 1'b0);
    run_cols(1, 1'b1, 1'b0);
    run_cols(COL_WINDOW, 1'b0, 1'b0);
    // Both inputs high counts as local.
    run_cols(4, 1'b1, 1'b1);
    run_cols(COL_WINDOW, 1'b0, 1'b0);
    // Saturation on the narrow counter, then clear on an entry.
    for (int k = 0; k < 5; k++) begin
      run_cols(4, 1'b1, 1'b0);
      run_cols(COL_WINDOW, 1'b0, 1'b0);
    end
    run_cols(3, 1'b1, 1'b0);
    col(1'b1, 1'b0, 1'b1, 1'b1);
    run_cols(COL_WINDOW, 1'b0, 1'b0);
    // Enable dropped while in remote fault.
    run_cols(4, 1'b0, 1'b1);
    col(1'b0, 1'b1, 1'b0, 1'b0);
    run_cols(2, 1'b0, 1'b0);
    // Asynchronous reset mid-detection.
    run_cols(2, 1'b1, 1'b0);
    do_reset(2);

    for (int s = 0; s < 500; s++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        n  = $urandom_range(1, 6);
        ty = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
          t = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : ty;
          col(t[1], t[0], 1'b1, $urandom_range(0, 49) == 0);
        end
      end else if (r < 80) begin
        run_cols($urandom_range(1, 40), 1'b0, 1'b0);
      end else if (r < 90) begin
        run_cols($urandom_range(COL_WINDOW - 8, COL_WINDOW + 7), 1'b0, 1'b0);
      end else if (r < 95) begin
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++)
          col($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0, 1'b0);
      end else if (r < 98) begin
        col($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1, 1'b1);
      end else begin
        do_reset($urandom_range(1, 3));
      end
    end

    repeat (3) @(posedge rxclk_2x);
    #2;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d entries exp=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_link_fault_monitor.md
# rx_link_fault_monitor

Parametrised link fault signalling monitor for the 10G MAC receive path. It sits after the RX decode stage on rxclk_2x and samples per-column local/remote fault indications. It qualifies a fault after a programmable number of matching sequence columns, and drops it after a programmable quiet window. Beyond the fixed-threshold link fault state machine, it adds enable gating, a change pulse, sticky status bits and per-type saturating event counters for the management block.

## Interface
Parameters:
- SEQ_THRESH, 4: matching fault-sequence columns needed to declare a fault (legal range 2 to 15).
- COL_WINDOW, 128: consecutive non-fault columns that clear a fault or abort detection (legal range 2 to 1024).
- CNT_W, 16: width of each fault event counter.

Ports:
- rxclk_2x, input, 1: receive clock; the only clock in the block.
- reset, input, 1: asynchronous, active-high reset.
- enable, input, 1: monitor enable. When low, the FSM is synchronously forced to IDLE.
- local_fault, input, 1: the current column is a local fault sequence.
- remote_fault, input, 1: the current column is a remote fault sequence.
- clr_stats, input, 1: synchronous clear of fault_sticky and both counters.
- link_fault, output, 2: qualified fault state. 00 means OK, 10 means local, 01 means remote.
- fault_change, output, 1: one-cycle pulse that coincides with any change of link_fault.
- fault_sticky, output, 2: sticky OR of every link_fault value asserted.
- local_fault_cnt, output, CNT_W: number of entries into the local fault state; saturates.
- remote_fault_cnt, output, CNT_W: number of entries into the remote fault state; saturates.

## Operation
Input type decode, evaluated each cycle:
- in_type = 10 if local_fault is high, else 01 if remote_fault is high, else 00.
- Local has priority when both inputs are high.
- fault_present = (in_type != 00).

Internal registers:
- cur_type, 2 bits.
- seq_cnt, wide enough to hold SEQ_THRESH.
- col_cnt, wide enough to hold COL_WINDOW.

States: IDLE, DETECT, FAULT.

IDLE:
- link_fault = 00.
- If fault_present: cur_type <= in_type, seq_cnt <= 1, col_cnt <= 0, go to DETECT.

DETECT, fault_present and in_type == cur_type:
- col_cnt <= 0.
- If seq_cnt + 1 == SEQ_THRESH: link_fault <= cur_type, seq_cnt <= 0, go to FAULT.
- Otherwise seq_cnt <= seq_cnt + 1.

DETECT, fault_present and in_type != cur_type:
- cur_type <= in_type, seq_cnt <= 1, col_cnt <= 0, stay in DETECT.

DETECT, no fault_present:
- If col_cnt == COL_WINDOW - 1: go to IDLE, link_fault <= 00, seq_cnt <= 0.
- Otherwise col_cnt <= col_cnt + 1.

FAULT, fault_present and in_type == cur_type:
- col_cnt <= 0.

FAULT, fault_present and in_type != cur_type:
- cur_type <= in_type, seq_cnt <= 1, col_cnt <= 0, go to DETECT.
- link_fault holds its old value until the new type qualifies or the window expires.

FAULT, no fault_present:
- Same window rule as DETECT: go to IDLE with link_fault <= 00 when col_cnt == COL_WINDOW - 1.

General rules:
- link_fault changes only on entry to FAULT or entry to IDLE.
- enable low: go to IDLE next edge; link_fault <= 00, seq_cnt <= 0, col_cnt <= 0. Statistics hold.
- Re-qualifying the same type already shown on link_fault counts as an entry (counter increments) but produces no fault_change pulse.

Statistics:
- On each entry to FAULT, increment the counter matching cur_type. A counter at all ones holds its value.
- fault_sticky <= fault_sticky | next link_fault value.
- When clr_stats coincides with a set or increment, the clear applies first and the new event is then recorded. The sticky bit reads set; the counter reads 1.

## Timing
- All outputs are registered. Reset values: link_fault 00, fault_change 0, fault_sticky 00, both counters 0, state IDLE.
- Qualification latency: link_fault updates on the edge that samples the SEQ_THRESH-th consecutive matching column, and is visible in the following cycle.
- Non-fault columns between matching sequences do not break the run unless COL_WINDOW of them occur in a row.
- Clear latency: the k-th consecutive non-fault column with k == COL_WINDOW causes IDLE and link_fault = 00 on that edge.
- fault_change is high in exactly the cycles in which link_fault differs from its previous-cycle value.
- Asynchronous reset mid-operation returns everything to the reset values immediately. The first sampled column after release is evaluated from IDLE.

## Test plan
- Defaults, 4 consecutive local_fault columns: link_fault = 10 one cycle after the 4th; fault_change pulses once; local_fault_cnt = 1; fault_sticky = 10.
- 3 remote columns, then a local column, then 3 more local columns: no fault after the remote run; link_fault = 10 after the 4th local column; remote_fault_cnt = 0.
- In FAULT (10), 127 idle columns then one local column, then 128 idle columns: stays 10 through the first gap; goes to 00 with a fault_change pulse on the 128th idle column.
- Both inputs high for 4 columns: treated as local; link_fault = 10.
- Counter saturation with CNT_W = 2: drive 5 local qualify/clear cycles; local_fault_cnt sticks at 3. Then clr_stats on the cycle of a 6th entry: counter = 1, fault_sticky = 10.
- enable dropped while in FAULT (01): link_fault = 00 next cycle with a fault_change pulse; counters unchanged. Asynchronous reset asserted mid-DETECT: all outputs go to zero.
